// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that shares one ALU between two requesters.
// Operands are registered on accept; the result is returned over a valid/ready response.
module alu_share_ctrl #(
  parameter int unsigned DSIZE   = 16,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [DSIZE-1:0] req0_a,
  input  logic [DSIZE-1:0] req0_b,
  input  logic [DSIZE-1:0] req0_imm,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [DSIZE-1:0] req1_a,
  input  logic [DSIZE-1:0] req1_b,
  input  logic [DSIZE-1:0] req1_imm,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [DSIZE-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [DSIZE-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [DSIZE-1:0] alu_a,
  output logic [DSIZE-1:0] alu_b,
  output logic [DSIZE-1:0] alu_imm,
  output logic [2:0]       alu_op,
  input  logic [DSIZE-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  localparam int unsigned OPW = 3;
  localparam int unsigned CW  = 4;
  localparam logic [OPW-1:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, MULW, RESP} state_t;

  state_t           state_q, state_d;
  logic [OPW-1:0]   op_q;
  logic [DSIZE-1:0] a_q, b_q, imm_q, res_q;
  logic             zero_q, owner_q, last_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             grant_idx, take, cap_res;

  // Next-state, grant and response decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_idx  = 1'b0;
    take       = 1'b0;
    cap_res    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie, the requester that did not win last time gets the grant
        if (req0_valid && req1_valid) grant_idx = ~last_q;
        else                          grant_idx = req1_valid;
        if (req0_valid || req1_valid) begin
          take       = 1'b1;
          req0_ready = ~grant_idx;
          req1_ready = grant_idx;
          cnt_d      = CW'(MUL_LAT - 1);
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (op_q != OP_MUL || MUL_LAT == 1) begin
          cap_res = 1'b1;
          state_d = RESP;
        end else begin
          state_d = MULW;
        end
      end
      MULW: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          cap_res = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        op_q    <= grant_idx ? req1_op  : req0_op;
        a_q     <= grant_idx ? req1_a   : req0_a;
        b_q     <= grant_idx ? req1_b   : req0_b;
        imm_q   <= grant_idx ? req1_imm : req0_imm;
        owner_q <= grant_idx;
        last_q  <= grant_idx;
      end
      if (cap_res) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_imm     = imm_q;
  assign alu_op      = op_q;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU attached to the alu_* port.
module tb_alu_share_ctrl;

  localparam int unsigned DSIZE = 16;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd4, SLL = 3'd5, MUL = 3'd7;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op, alu_op;
  logic [DSIZE-1:0] req0_a, req0_b, req0_imm, req1_a, req1_b, req1_imm;
  logic rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [DSIZE-1:0] rsp0_result, rsp1_result;
  logic [DSIZE-1:0] alu_a, alu_b, alu_imm, alu_result;
  logic alu_zero, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DSIZE(DSIZE), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_imm(req1_imm),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // Behavioural ALU
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd5:    alu_result = alu_a << alu_imm[3:0];
      3'd6:    alu_result = alu_a >> alu_imm[3:0];
      default: alu_result = 16'(alu_a * alu_b);
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_req0(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] imm);
    req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_imm = imm;
  endtask

  task automatic set_req1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] imm);
    req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_imm = imm;
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_imm = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_imm = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_result", rsp0_result, 0);

    // ADD 5+3 from requester 0
    nxt(); set_req0(ADD, 16'h0005, 16'h0003, 16'h0000); #1;
    check("add_req0_ready", req0_ready, 1);
    check("add_req1_ready", req1_ready, 0);
    check("add_idle_busy", busy, 0);
    nxt(); req0_valid = 1'b0; #1;
    check("add_exec_busy", busy, 1);
    check("add_exec_ready", req0_ready, 0);
    check("add_exec_rsp", rsp0_valid, 0);
    check("add_alu_a", alu_a, 16'h0005);
    check("add_alu_b", alu_b, 16'h0003);
    nxt(); rsp0_ready = 1'b1; #1;
    check("add_rsp_valid", rsp0_valid, 1);
    check("add_result", rsp0_result, 16'h0008);
    check("add_zero", rsp0_zero, 0);
    check("add_rsp_busy", busy, 1);
    check("add_rsp1_valid", rsp1_valid, 0);
    nxt(); rsp0_ready = 1'b0; #1;
    check("add_back_idle", busy, 0);
    check("add_rsp_drop", rsp0_valid, 0);

    // Round-robin with both requesters continuously valid
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    nxt();
    set_req0(SUB, 16'h0007, 16'h0007, 16'h0000);
    set_req1(XOR, 16'hF0F0, 16'h0F0F, 16'h0000);
    #1;
    check("rr_g0_r0", req0_ready, 1);
    check("rr_g0_r1", req1_ready, 0);
    nxt(); #1;
    check("rr_exec_r0", req0_ready, 0);
    check("rr_exec_r1", req1_ready, 0);
    check("rr_exec_op", alu_op, SUB);
    nxt(); #1;
    check("rr_rsp0_valid", rsp0_valid, 1);
    check("rr_rsp1_idle", rsp1_valid, 0);
    check("rr_rsp0_result", rsp0_result, 16'h0000);
    check("rr_rsp0_zero", rsp0_zero, 1);
    nxt(); #1;
    check("rr_g1_r1", req1_ready, 1);
    check("rr_g1_r0", req0_ready, 0);
    nxt(); #1;
    check("rr_exec2_op", alu_op, XOR);
    nxt(); #1;
    check("rr_rsp1_valid", rsp1_valid, 1);
    check("rr_rsp0_idle", rsp0_valid, 0);
    check("rr_rsp1_result", rsp1_result, 16'hFFFF);
    check("rr_rsp1_zero", rsp1_zero, 0);
    nxt(); #1;
    check("rr_g2_r0", req0_ready, 1);
    check("rr_g2_r1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // MUL with three held cycles
    nxt(); set_req0(MUL, 16'h0012, 16'h0003, 16'h0000); #1;
    check("mul_ready", req0_ready, 1);
    for (int i = 0; i < 3; i++) begin
      nxt(); req0_valid = 1'b0; #1;
      check("mul_hold_a", alu_a, 16'h0012);
      check("mul_hold_b", alu_b, 16'h0003);
      check("mul_hold_op", alu_op, MUL);
      check("mul_no_rsp", rsp0_valid, 0);
      check("mul_busy", busy, 1);
    end
    nxt(); rsp0_ready = 1'b1; #1;
    check("mul_rsp_valid", rsp0_valid, 1);
    check("mul_result", rsp0_result, 16'h0036);
    nxt(); rsp0_ready = 1'b0; #1;
    check("mul_idle", busy, 0);

    // SLL on requester 1 under response backpressure
    nxt(); set_req1(SLL, 16'h0001, 16'h0000, 16'h0004); #1;
    check("sll_ready", req1_ready, 1);
    nxt(); req1_valid = 1'b0; #1;
    check("sll_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      nxt();
      if (i == 0) set_req0(ADD, 16'h0001, 16'h0001, 16'h0000);
      #1;
      check("bp_rsp1_valid", rsp1_valid, 1);
      check("bp_result", rsp1_result, 16'h0010);
      check("bp_req0_ready", req0_ready, 0);
      check("bp_rsp0_valid", rsp0_valid, 0);
    end
    rsp1_ready = 1'b1;
    nxt(); rsp1_ready = 1'b0; #1;
    check("bp_idle", busy, 0);
    check("bp_rsp1_drop", rsp1_valid, 0);
    check("bp_req0_grant", req0_ready, 1);
    nxt(); req0_valid = 1'b0; #1;
    check("bp_exec_a", alu_a, 16'h0001);
    nxt(); rsp0_ready = 1'b1; #1;
    check("bp_rsp0_valid_after", rsp0_valid, 1);
    check("bp_rsp0_result", rsp0_result, 16'h0002);
    nxt(); rsp0_ready = 1'b0;

    // Reset while a MUL is in MULW
    nxt(); set_req0(MUL, 16'h0002, 16'h0003, 16'h0000); rsp0_ready = 1'b1; #1;
    nxt(); req0_valid = 1'b0; #1;
    check("mrst_exec", busy, 1);
    nxt(); #1;
    check("mrst_mulw", busy, 1);
    check("mrst_mulw_rsp", rsp0_valid, 0);
    rst = 1'b1;
    nxt(); rst = 1'b0; #1;
    check("mrst_busy", busy, 0);
    check("mrst_rsp0", rsp0_valid, 0);
    check("mrst_rsp1", rsp1_valid, 0);
    check("mrst_alu_a", alu_a, 0);
    check("mrst_alu_b", alu_b, 0);
    check("mrst_alu_op", alu_op, 0);
    check("mrst_result", rsp0_result, 0);
    check("mrst_zero", rsp0_zero, 0);
    check("mrst_req0_ready", req0_ready, 0);
    for (int i = 0; i < 5; i++) begin
      nxt(); #1;
      check("mrst_no_rsp", rsp0_valid, 0);
    end
    rsp0_ready = 1'b0;

    // Requester 1 pulses valid during RESP and is never granted
    nxt(); set_req0(ADD, 16'h0002, 16'h0002, 16'h0000); #1;
    check("pulse_accept", req0_ready, 1);
    nxt(); req0_valid = 1'b0;
    nxt(); set_req1(SUB, 16'h0009, 16'h0001, 16'h0000); #1;
    check("pulse_rsp0", rsp0_valid, 1);
    check("pulse_r1_ready", req1_ready, 0);
    nxt(); req1_valid = 1'b0; rsp0_ready = 1'b1; #1;
    check("pulse_r1_ready2", req1_ready, 0);
    check("pulse_result", rsp0_result, 16'h0004);
    for (int i = 0; i < 4; i++) begin
      nxt(); rsp0_ready = 1'b0; #1;
      check("pulse_idle", busy, 0);
      check("pulse_no_rsp1", rsp1_valid, 0);
      check("pulse_no_grant", req1_ready, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
